// File: rtl/traffic_light_monitor.sv
// Traffic light lamp monitor: decodes lamp pattern into a phase, times each phase in whole
// seconds, checks pattern/order/duration and keeps a sticky first-error code and cycle count.
module traffic_light_monitor #(
  parameter int unsigned CLK_HZ = 24_000_000,
  parameter int unsigned SURE_A = 10,
  parameter int unsigned SURE_B = 9,
  parameter int unsigned SURE_C = 31,
  parameter int unsigned TOL    = 1
) (
  input  logic       sayac,
  input  logic       reset,
  input  logic       kirmizi,
  input  logic       mavi,
  input  logic       yesil,
  input  logic       hata_temizle,
  output logic [1:0] faz,
  output logic [7:0] faz_sure,
  output logic [7:0] son_sure,
  output logic       son_gecerli,
  output logic       hata,
  output logic [2:0] hata_kod,
  output logic [7:0] tur_sayisi
);

  localparam int unsigned   PW       = $clog2(CLK_HZ);
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    FazRst = 2'd0,
    FazA   = 2'd1,
    FazB   = 2'd2,
    FazC   = 2'd3
  } faz_e;

  logic [2:0]    giris_r;
  logic [PW-1:0] presc_q;
  faz_e          faz_q, faz_d, giris_faz;
  logic          giris_legal, degisim, gecis_ok, tick;
  logic [31:0]   beklenen;
  logic [2:0]    hata_yeni, kod_taban;

  always_ff @(posedge sayac or posedge reset) begin
    if (reset) begin
      giris_r <= 3'b100;
    end else begin
      giris_r <= {kirmizi, mavi, yesil};
    end
  end

  // Illegal patterns keep the current phase so timing carries on undisturbed.
  always_comb begin
    giris_legal = 1'b1;
    giris_faz   = faz_q;
    case (giris_r)
      3'b100:  giris_faz = FazRst;
      3'b011:  giris_faz = FazA;
      3'b010:  giris_faz = FazB;
      3'b110:  giris_faz = FazC;
      default: giris_legal = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge sayac or posedge reset) begin
    if (reset) begin
      faz_q <= FazRst;
    end else begin
      faz_q <= faz_d;
    end
  end

  // Next state
  always_comb begin
    degisim  = giris_legal && (giris_faz != faz_q);
    gecis_ok = 1'b0;
    unique case (faz_q)
      FazRst: gecis_ok = (giris_faz == FazA);
      FazA:   gecis_ok = (giris_faz == FazB);
      FazB:   gecis_ok = (giris_faz == FazC);
      FazC:   gecis_ok = (giris_faz == FazA);
      default: gecis_ok = 1'b0;
    endcase
    faz_d = degisim ? giris_faz : faz_q;
  end

  assign tick = (presc_q == PrescMax);

  // Error detection; lowest code wins when several fire together.
  always_comb begin
    beklenen = 32'd0;
    case (faz_q)
      FazA:    beklenen = SURE_A;
      FazB:    beklenen = SURE_B;
      FazC:    beklenen = SURE_C;
      default: beklenen = 32'd0;
    endcase

    hata_yeni = 3'd0;
    if (!giris_legal) begin
      hata_yeni = 3'd1;
    end else if (degisim && !gecis_ok) begin
      hata_yeni = 3'd2;
    end else if (degisim && (faz_q != FazRst) && ((32'(faz_sure) + TOL) < beklenen)) begin
      hata_yeni = 3'd3;
    end else if (!degisim && tick && (faz_q != FazRst) && (faz_sure != 8'hFF) &&
                 (32'(faz_sure) == (beklenen + TOL))) begin
      hata_yeni = 3'd4;
    end

    kod_taban = hata_temizle ? 3'd0 : hata_kod;
  end

  always_ff @(posedge sayac or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      faz_sure    <= 8'd0;
      son_sure    <= 8'd0;
      son_gecerli <= 1'b0;
      hata        <= 1'b0;
      hata_kod    <= 3'd0;
      tur_sayisi  <= 8'd0;
    end else begin
      son_gecerli <= degisim;
      // A tick landing on the phase-change edge is dropped; the new phase starts at 0.
      if (degisim) begin
        presc_q  <= '0;
        faz_sure <= 8'd0;
        son_sure <= faz_sure;
        if ((faz_q == FazC) && (giris_faz == FazA)) begin
          tur_sayisi <= tur_sayisi + 8'd1;
        end
      end else if (tick) begin
        presc_q <= '0;
        if (faz_sure != 8'hFF) begin
          faz_sure <= faz_sure + 8'd1;
        end
      end else begin
        presc_q <= presc_q + PW'(1);
      end
      hata     <= (hata_yeni != 3'd0) || (hata && !hata_temizle);
      hata_kod <= (kod_taban == 3'd0) ? hata_yeni : kod_taban;
    end
  end

  assign faz = faz_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: directed vector table, hand sequences for saturation,
// wrap and mid-phase reset, then random lamp sequences against a cycle-count reference model.
module tb_traffic_light_monitor;

  localparam int HZ  = 4;
  localparam int TOL = 1;

  logic       sayac = 1'b0;
  logic       reset = 1'b0;
  logic       kirmizi = 1'b1, mavi = 1'b0, yesil = 1'b0;
  logic       hata_temizle = 1'b0;
  logic [1:0] faz;
  logic [7:0] faz_sure, son_sure, tur_sayisi;
  logic       son_gecerli, hata;
  logic [2:0] hata_kod;

  traffic_light_monitor #(
    .CLK_HZ(HZ),
    .SURE_A(10),
    .SURE_B(9),
    .SURE_C(31),
    .TOL   (TOL)
  ) dut (
    .sayac       (sayac),
    .reset       (reset),
    .kirmizi     (kirmizi),
    .mavi        (mavi),
    .yesil       (yesil),
    .hata_temizle(hata_temizle),
    .faz         (faz),
    .faz_sure    (faz_sure),
    .son_sure    (son_sure),
    .son_gecerli (son_gecerli),
    .hata        (hata),
    .hata_kod    (hata_kod),
    .tur_sayisi  (tur_sayisi)
  );

  always #5 sayac = ~sayac;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: phase length kept as a raw count of edges since phase entry.
  int m_giris, m_faz, m_k, m_son, m_gec, m_hata, m_kod, m_tur;

  function automatic int dec(input int g);
    case (g)
      4:       return 0;
      3:       return 1;
      2:       return 2;
      6:       return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int exp_dur(input int f);
    case (f)
      1:       return 10;
      2:       return 9;
      3:       return 31;
      default: return 0;
    endcase
  endfunction

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    m_giris = 4; m_faz = 0; m_k = 0; m_son = 0; m_gec = 0;
    m_hata = 0; m_kod = 0; m_tur = 0;
  endtask

  task automatic model_step(input int lamps, input bit clr);
    int p, fs, err, kb;
    bit legal;
    p       = dec(m_giris);
    m_giris = lamps;
    fs      = sat(m_k / HZ);
    err     = 0;
    m_gec   = 0;
    if (p >= 0 && p != m_faz) begin
      legal = (p == ((m_faz == 3) ? 1 : m_faz + 1));
      if (!legal) err = 2;
      else if (m_faz != 0 && fs < exp_dur(m_faz) - TOL) err = 3;
      if (legal && m_faz == 3) m_tur = (m_tur + 1) % 256;
      m_son = fs;
      m_gec = 1;
      m_faz = p;
      m_k   = 0;
    end else begin
      if (p < 0) err = 1;
      m_k++;
      if (err == 0 && m_faz != 0 && m_k == HZ * (exp_dur(m_faz) + TOL + 1)) err = 4;
    end
    if (err != 0) begin
      kb     = clr ? 0 : m_kod;
      m_hata = 1;
      m_kod  = (kb == 0) ? err : kb;
    end else if (clr) begin
      m_hata = 0;
      m_kod  = 0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive lamps away from the active edge, then compare every output against the model.
  task automatic cyc(input logic [2:0] lamps, input bit clr);
    {kirmizi, mavi, yesil} = lamps;
    hata_temizle = clr;
    @(posedge sayac);
    #1;
    model_step(int'(lamps), clr);
    chk("faz", int'(faz), m_faz);
    chk("faz_sure", int'(faz_sure), sat(m_k / HZ));
    chk("son_sure", int'(son_sure), m_son);
    chk("son_gecerli", int'(son_gecerli), m_gec);
    chk("hata", int'(hata), m_hata);
    chk("hata_kod", int'(hata_kod), m_kod);
    chk("tur_sayisi", int'(tur_sayisi), m_tur);
    @(negedge sayac);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_faz", int'(faz), 0);
    chk("rst_faz_sure", int'(faz_sure), 0);
    chk("rst_son_sure", int'(son_sure), 0);
    chk("rst_son_gecerli", int'(son_gecerli), 0);
    chk("rst_hata", int'(hata), 0);
    chk("rst_hata_kod", int'(hata_kod), 0);
    chk("rst_tur", int'(tur_sayisi), 0);
    model_reset();
    @(posedge sayac);
    @(negedge sayac);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [2:0] lamps;
    int         n;
    bit         clr;
    int         faz;
    int         son;
    int         hata;
    int         kod;
    int         tur;
  } vec_t;

  vec_t       tbl[19];
  logic [2:0] pats[4];

  initial begin
    int         r, n, e, rot;
    logic [2:0] p;

    pats[0] = 3'b100; pats[1] = 3'b011; pats[2] = 3'b010; pats[3] = 3'b110;

    // A tick on the exit edge is dropped, so each golden phase is held one extra cycle
    // to bank its full 10/9/31 s.
    tbl[0]  = '{3'b100,   3, 1'b0, 0,  0, 0, 0, 0};
    tbl[1]  = '{3'b011,  41, 1'b0, 1,  1, 0, 0, 0};
    tbl[2]  = '{3'b010,  37, 1'b0, 2, 10, 0, 0, 0};
    tbl[3]  = '{3'b110, 125, 1'b0, 3,  9, 0, 0, 0};
    tbl[4]  = '{3'b011,  41, 1'b0, 1, 31, 0, 0, 1};
    tbl[5]  = '{3'b111,   1, 1'b0, 1, 31, 0, 0, 1};
    tbl[6]  = '{3'b011,   1, 1'b0, 1, 31, 1, 1, 1};
    tbl[7]  = '{3'b011,   2, 1'b1, 1, 31, 0, 0, 1};
    tbl[8]  = '{3'b110,   3, 1'b0, 3, 11, 1, 2, 1};
    tbl[9]  = '{3'b011,   2, 1'b0, 1,  0, 1, 2, 2};
    tbl[10] = '{3'b011,   1, 1'b1, 1,  0, 0, 0, 2};
    tbl[11] = '{3'b011,  38, 1'b0, 1,  0, 0, 0, 2};
    tbl[12] = '{3'b010,  29, 1'b0, 2, 10, 0, 0, 2};
    tbl[13] = '{3'b110,   1, 1'b0, 2, 10, 0, 0, 2};
    tbl[14] = '{3'b110,   1, 1'b0, 3,  7, 1, 3, 2};
    tbl[15] = '{3'b110,   1, 1'b1, 3,  7, 0, 0, 2};
    tbl[16] = '{3'b110, 130, 1'b0, 3,  7, 0, 0, 2};
    tbl[17] = '{3'b110,   1, 1'b0, 3,  7, 1, 4, 2};
    tbl[18] = '{3'b011,   2, 1'b1, 1, 33, 0, 0, 3};

    model_reset();
    #2;
    do_reset();

    for (int i = 0; i < 19; i++) begin
      for (int c = 0; c < tbl[i].n; c++) cyc(tbl[i].lamps, tbl[i].clr);
      chk($sformatf("row%0d_faz", i), int'(faz), tbl[i].faz);
      chk($sformatf("row%0d_son", i), int'(son_sure), tbl[i].son);
      chk($sformatf("row%0d_hata", i), int'(hata), tbl[i].hata);
      chk($sformatf("row%0d_kod", i), int'(hata_kod), tbl[i].kod);
      chk($sformatf("row%0d_tur", i), int'(tur_sayisi), tbl[i].tur);
    end

    // Saturation of faz_sure in RST
    do_reset();
    for (int c = 0; c < 1100; c++) cyc(3'b100, 1'b0);
    chk("sat_faz_sure", int'(faz_sure), 255);
    chk("sat_faz", int'(faz), 0);

    // Cycle counter wrap with one-cycle phases
    cyc(3'b011, 1'b0);
    cyc(3'b011, 1'b0);
    for (int i = 0; i < 256; i++) begin
      cyc(3'b010, 1'b0);
      if (i == 255) chk("wrap_tur_255", int'(tur_sayisi), 255);
      cyc(3'b110, 1'b0);
      cyc(3'b011, 1'b0);
    end
    cyc(3'b011, 1'b0);
    chk("wrap_tur_0", int'(tur_sayisi), 0);
    chk("wrap_kod", int'(hata_kod), 3);

    // Reset in the middle of phase C
    for (int c = 0; c < 3; c++) cyc(3'b010, 1'b0);
    for (int c = 0; c < 6; c++) cyc(3'b110, 1'b0);
    chk("pre_rst_faz", int'(faz), 3);
    do_reset();
    cyc(3'b011, 1'b0);
    cyc(3'b011, 1'b0);
    chk("post_rst_faz", int'(faz), 1);
    chk("post_rst_gec", int'(son_gecerli), 1);
    chk("post_rst_hata", int'(hata), 0);
    chk("post_rst_kod", int'(hata_kod), 0);

    // Random lamp sequences around the tolerance boundaries
    rot = 1;
    for (int s = 0; s < 250; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        p   = pats[rot];
        e   = exp_dur(rot);
        n   = int'($urandom_range(HZ * (e - TOL) - 2, HZ * (e + TOL + 2) + 2));
        rot = (rot == 3) ? 1 : rot + 1;
      end else if (r == 7) begin
        p = 3'($urandom_range(0, 7));
        n = int'($urandom_range(1, 3));
      end else begin
        p = pats[$urandom_range(0, 3)];
        n = int'($urandom_range(1, 60));
      end
      for (int c = 0; c < n; c++) cyc(p, ($urandom_range(0, 15) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
